// File: rtl/sc_xnor_pkg.sv
// Shared constants and width helpers for the masked XNOR comparator.
package sc_xnor_pkg;

    localparam int STREAK_DEFAULT = 4;

    // Bits needed to hold a ones-count of 0..dataWidth inclusive.
    function automatic int cntWidth(input int dataWidth);
        return $clog2(dataWidth + 1);
    endfunction

endpackage

// File: rtl/sc_xnor_comparator_popcount.sv
// Combinational ones-count: the vector is zero-padded to a power of two and reduced as a binary adder tree.
module cc_popcount #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0] vec,
    output logic [CNT_WIDTH-1:0]  ones
);

    localparam int LEAVES = 1 << $clog2(DATA_WIDTH);
    localparam int NODES  = 2 * LEAVES - 1;

    logic [LEAVES-1:0]    padded;
    logic [CNT_WIDTH-1:0] node [NODES];

    assign padded = LEAVES'(vec);

    // Heap layout: leaves occupy the upper half, node k sums children 2k+1 and 2k+2.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            node[LEAVES-1+i] = CNT_WIDTH'(padded[i]);
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
    end

    assign ones = node[0];

endmodule

// File: rtl/sc_xnor_comparator.sv
// Two-stage masked XNOR comparator: equality, thresholded near-equality and a saturating exact-match streak.
module sc_xnor_comparator
    import sc_xnor_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  STREAK_WIDTH = STREAK_DEFAULT,
    localparam int CNT_WIDTH    = cntWidth(DATA_WIDTH)
) (
    input  logic                    SC_XnorComparator_CLOCK_50,
    input  logic                    SC_XnorComparator_RESET_InLow,
    input  logic                    clear_In,
    input  logic                    valid_In,
    input  logic [DATA_WIDTH-1:0]   a_In,
    input  logic [DATA_WIDTH-1:0]   b_In,
    input  logic [DATA_WIDTH-1:0]   mask_In,
    input  logic [CNT_WIDTH-1:0]    threshold_In,
    output logic                    valid_Out,
    output logic [DATA_WIDTH-1:0]   xnor_Out,
    output logic [CNT_WIDTH-1:0]    count_Out,
    output logic                    exact_Out,
    output logic                    near_Out,
    output logic [STREAK_WIDTH-1:0] streak_Out,
    output logic                    streak_sat_Out
);

    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = '1;

    function automatic logic [STREAK_WIDTH-1:0] satIncStreak(input logic [STREAK_WIDTH-1:0] cur);
        return (cur == STREAK_MAX) ? cur : cur + 1'b1;
    endfunction

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   xnorVec_p1;
    logic [CNT_WIDTH-1:0]    thrCap_p1;
    logic [CNT_WIDTH-1:0]    ones_p1;

    logic                    vld_p2;
    logic [DATA_WIDTH-1:0]   xnorVec_p2;
    logic [CNT_WIDTH-1:0]    count_p2;
    logic                    exact_p2;
    logic                    near_p2;
    logic [STREAK_WIDTH-1:0] streak_p2;

    // Stage 1: masked XNOR and threshold capture
    always_ff @(posedge SC_XnorComparator_CLOCK_50 or negedge SC_XnorComparator_RESET_InLow) begin
        if (!SC_XnorComparator_RESET_InLow) begin
            vld_p1     <= 1'b0;
            xnorVec_p1 <= '0;
            thrCap_p1  <= '0;
        end else if (clear_In) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= valid_In;
            if (valid_In) begin
                xnorVec_p1 <= ~(a_In ^ b_In) | ~mask_In;
                thrCap_p1  <= threshold_In;
            end
        end
    end

    cc_popcount #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) uPopcount (
        .vec  (xnorVec_p1),
        .ones (ones_p1)
    );

    // Stage 2: count, equality flags and streak
    always_ff @(posedge SC_XnorComparator_CLOCK_50 or negedge SC_XnorComparator_RESET_InLow) begin
        if (!SC_XnorComparator_RESET_InLow) begin
            vld_p2     <= 1'b0;
            xnorVec_p2 <= '0;
            count_p2   <= '0;
            exact_p2   <= 1'b0;
            near_p2    <= 1'b0;
            streak_p2  <= '0;
        end else if (clear_In) begin
            vld_p2    <= 1'b0;
            streak_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                xnorVec_p2 <= xnorVec_p1;
                count_p2   <= ones_p1;
                exact_p2   <= &xnorVec_p1;
                near_p2    <= (ones_p1 >= thrCap_p1);
                streak_p2  <= (&xnorVec_p1) ? satIncStreak(streak_p2) : '0;
            end
        end
    end

    assign valid_Out      = vld_p2;
    assign xnor_Out       = xnorVec_p2;
    assign count_Out      = count_p2;
    assign exact_Out      = exact_p2;
    assign near_Out       = near_p2;
    assign streak_Out     = streak_p2;
    assign streak_sat_Out = (streak_p2 == STREAK_MAX);

endmodule

// File: tb/tb_sc_xnor_comparator.sv
// Scoreboard bench for sc_xnor_comparator: expected results are queued on drive and popped when valid_Out fires.
module tb_sc_xnor_comparator;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          clr = 1'b0;
    logic          vld = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [DW-1:0] mask = '0;
    logic [CW-1:0] thr = '0;

    logic          vOut;
    logic [DW-1:0] xOut;
    logic [CW-1:0] cOut;
    logic          eOut;
    logic          nOut;
    logic [SW-1:0] sOut;
    logic          satOut;

    always #5 clk = ~clk;

    sc_xnor_comparator #(
        .DATA_WIDTH   (DW),
        .STREAK_WIDTH (SW)
    ) dut (
        .SC_XnorComparator_CLOCK_50    (clk),
        .SC_XnorComparator_RESET_InLow (rstN),
        .clear_In                      (clr),
        .valid_In                      (vld),
        .a_In                          (a),
        .b_In                          (b),
        .mask_In                       (mask),
        .threshold_In                  (thr),
        .valid_Out                     (vOut),
        .xnor_Out                      (xOut),
        .count_Out                     (cOut),
        .exact_Out                     (eOut),
        .near_Out                      (nOut),
        .streak_Out                    (sOut),
        .streak_sat_Out                (satOut)
    );

    typedef struct {
        logic [DW-1:0] x;
        logic [CW-1:0] cnt;
        logic          ex;
        logic          nr;
        logic [SW-1:0] stk;
        int            stamp;
    } exp_t;

    exp_t          q[$];
    exp_t          st1;
    exp_t          mo;
    bit            st1Valid = 1'b0;
    logic [SW-1:0] mStreak = '0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] lastX = '0;
    logic [CW-1:0] lastC = '0;
    logic          lastE = 1'b0;
    logic          lastN = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string p);
        chk({p, "Valid"}, vOut, 0);
        chk({p, "Xnor"}, xOut, 0);
        chk({p, "Count"}, cOut, 0);
        chk({p, "Exact"}, eOut, 0);
        chk({p, "Near"}, nOut, 0);
        chk({p, "Streak"}, sOut, 0);
        chk({p, "Sat"}, satOut, 0);
    endtask

    // Drive one cycle of inputs and advance the reference model across the coming edge.
    task automatic cycle(input logic v, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                         input logic [DW-1:0] im, input logic [CW-1:0] it, input logic ic);
        exp_t e;
        vld = v; a = ia; b = ib; mask = im; thr = it; clr = ic;
        if (ic) begin
            st1Valid = 1'b0;
            mStreak  = '0;
        end else begin
            if (st1Valid) begin
                if (st1.ex) mStreak = (mStreak < 4'd15) ? mStreak + 4'd1 : 4'd15;
                else        mStreak = '0;
                st1.stk = mStreak;
                q.push_back(st1);
            end
            st1Valid = v;
            if (v) begin
                e.x   = ~(ia ^ ib) | ~im;
                e.cnt = '0;
                for (int i = 0; i < DW; i++) e.cnt = e.cnt + CW'(e.x[i]);
                e.ex    = &e.x;
                e.nr    = (e.cnt >= it);
                e.stk   = '0;
                e.stamp = cyc + 2;
                st1     = e;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic flushModel();
        q.delete();
        st1Valid = 1'b0;
        mStreak  = '0;
        lastX = '0; lastC = '0; lastE = 1'b0; lastN = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            if (vOut) begin
                if (q.size() == 0) begin
                    chk("unexpectedValid", 1, 0);
                end else begin
                    mo = q.pop_front();
                    chk("latency", cyc, mo.stamp);
                    chk("xnor", xOut, mo.x);
                    chk("count", cOut, mo.cnt);
                    chk("exact", eOut, mo.ex);
                    chk("near", nOut, mo.nr);
                    chk("streak", sOut, mo.stk);
                    chk("streakSat", satOut, (mo.stk == 4'd15));
                    lastX = mo.x; lastC = mo.cnt; lastE = mo.ex; lastN = mo.nr;
                end
            end else begin
                chk("holdXnor", xOut, lastX);
                chk("holdCount", cOut, lastC);
                chk("holdExact", eOut, lastE);
                chk("holdNear", nOut, lastN);
            end
        end
    end

    initial begin
        // Reset, then idle
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("inRst");
        rstN = 1'b1;
        idle(3);
        checkAllZero("idle");

        // Exact and near match
        cycle(1'b1, 8'hA5, 8'hA5, 8'hFF, 4'd8, 1'b0);
        cycle(1'b1, 8'hA5, 8'hA4, 8'hFF, 4'd7, 1'b0);
        idle(2);

        // Mask and threshold edges
        cycle(1'b1, 8'h0F, 8'hF0, 8'h00, 4'd9, 1'b0);
        cycle(1'b1, 8'h0F, 8'hF0, 8'hFF, 4'd0, 1'b0);
        idle(2);

        // Streak saturation across an idle gap
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h3C, 8'h3C, 8'hFF, 4'd8, 1'b0);
        idle(3);
        chk("gapStreak", sOut, 15);
        chk("gapSat", satOut, 1);
        cycle(1'b1, 8'h3C, 8'h3C, 8'hFF, 4'd8, 1'b0);
        cycle(1'b1, 8'h3C, 8'h3D, 8'hFF, 4'd8, 1'b0);
        idle(2);

        // Clear collides with valid words
        cycle(1'b1, 8'h55, 8'h55, 8'hFF, 4'd3, 1'b0);
        idle(2);
        chk("preClrStreak", sOut, 1);
        cycle(1'b1, 8'h11, 8'h11, 8'hFF, 4'd8, 1'b0);
        cycle(1'b1, 8'h22, 8'h22, 8'hFF, 4'd8, 1'b1);
        chk("clrValid", vOut, 0);
        chk("clrStreak", sOut, 0);
        cycle(1'b1, 8'h12, 8'h13, 8'hFF, 4'd4, 1'b0);
        idle(3);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h66, 8'h66, 8'hFF, 4'd8, 1'b0);
        idle(1);
        @(negedge clk);
        #2;
        chk("preRstValid", vOut, 1);
        chk("preRstStreak", sOut, 5);
        rstN = 1'b0;
        #1;
        checkAllZero("asyncRst");
        flushModel();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle(1'b1, 8'hAA, 8'hAA, 8'hFF, 4'd8, 1'b0);
        idle(3);

        chk("queueDrained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
